// File: rtl/axi_arb_mon_pkg.sv
// Shared types and constants for the AW-channel arbitration monitor.
package axi_arb_mon_pkg;

  // Number of distinct violation classes tracked in the sticky register.
  localparam int ERR_W = 6;

  // Arbitration policy currently claimed by the arbiter under observation.
  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RR    = 2'd1,
    MODE_WRR   = 2'd2,
    MODE_RSVD  = 2'd3
  } arb_mode_e;

  // Violation codes; the value doubles as the bit index in err_sticky.
  typedef enum logic [2:0] {
    VIOL_MULTI  = 3'd0,
    VIOL_NOARB  = 3'd1,
    VIOL_PRIO   = 3'd2,
    VIOL_RR     = 3'd3,
    VIOL_WRR    = 3'd4,
    VIOL_STARVE = 3'd5
  } viol_code_e;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (vec[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axi_arb_monitor_if.sv
// Write-address handshake bundle for all monitored channels.
interface axi_arb_monitor_if #(
  parameter int NUM_CH = 3
);
  logic [NUM_CH-1:0] awvalid;
  logic [NUM_CH-1:0] awready;

  // The arbiter side drives the handshake; the monitor only observes it.
  modport master (output awvalid, output awready);
  modport slave  (input  awvalid, input  awready);
endinterface

// File: rtl/axi_arb_mon_ch.sv
// Per-channel history: run length of consecutive grants, stall length,
// and a one-cycle-delayed copy of AWVALID.
module axi_arb_mon_ch
  import axi_arb_mon_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int CH_IDX   = 0,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 256
) (
  input  logic              clk,
  input  logic              rst,
  axi_arb_monitor_if.slave  aw,
  input  logic              i_arb_en,
  output logic [CNT_W-1:0]  o_run_cnt,
  output logic              o_valid_q,
  output logic              o_starve
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] RUN_MAX  = '1;

  logic [NUM_CH-1:0] w_grant;
  logic              w_own_grant;
  logic              w_other_grant;
  logic              w_stall;
  logic [CNT_W-1:0]  r_run_cnt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_valid_q;

  assign w_grant       = aw.awvalid & aw.awready;
  assign w_own_grant   = w_grant[CH_IDX];
  assign w_other_grant = |(w_grant & ~(NUM_CH'(1) << CH_IDX));
  assign w_stall       = aw.awvalid[CH_IDX] & ~aw.awready[CH_IDX];

  // Starvation fires only on the cycle the stall count reaches the limit,
  // so a long stall reports once and then sits saturated.
  generate
    if (MAX_WAIT == 0) begin : g_no_starve
      assign o_starve = 1'b0;
    end else begin : g_starve
      assign o_starve = i_arb_en & w_stall & (r_wait_cnt == WAIT_LIM - 1'b1);
    end
  endgenerate

  // Consecutive-grant run: extend on own grant, restart on anyone else's.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt <= '0;
    end else if (i_arb_en && w_own_grant) begin
      if (r_run_cnt != RUN_MAX) r_run_cnt <= r_run_cnt + 1'b1;
    end else if (w_other_grant) begin
      r_run_cnt <= '0;
    end
  end

  // Stall length: counts valid-without-ready cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_stall) begin
      if (r_wait_cnt != WAIT_LIM) r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Previous-cycle AWVALID, used to decide whether another channel was waiting.
  always_ff @(posedge clk) begin
    if (rst) r_valid_q <= 1'b0;
    else     r_valid_q <= aw.awvalid[CH_IDX];
  end

  assign o_run_cnt = r_run_cnt;
  assign o_valid_q = r_valid_q;

endmodule

// File: rtl/axi_arb_monitor.sv
// Passive checker for an AW-channel arbiter: detects multi-grant, grants
// while disabled, fixed/round-robin/weighted policy breaches and starvation,
// and keeps sticky flags, a first-error record and a violation-cycle count.
module axi_arb_monitor
  import axi_arb_mon_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 16,
  parameter int WEIGHT_W = 16,
  parameter int MAX_WAIT = 256,
  parameter int RR_BURST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          awvalid,
  input  logic [NUM_CH-1:0]          awready,
  input  logic                       arb_en,
  input  logic [1:0]                 arb_mode,
  input  logic [NUM_CH*WEIGHT_W-1:0] weight,
  input  logic                       clr_err,
  output logic [ERR_W-1:0]           err_sticky,
  output logic                       err_pulse,
  output logic [2:0]                 first_code,
  output logic [2:0]                 first_ch,
  output logic [15:0]                err_cnt
);

  axi_arb_monitor_if #(.NUM_CH(NUM_CH)) w_aw_if ();

  assign w_aw_if.awvalid = awvalid;
  assign w_aw_if.awready = awready;

  arb_mode_e         w_mode;
  logic [NUM_CH-1:0] w_grant;
  logic [CNT_W-1:0]  w_run_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_valid_q;
  logic [NUM_CH-1:0] w_starve;
  logic [NUM_CH-1:0] w_prio_ch;
  logic [NUM_CH-1:0] w_rr_ch;
  logic [NUM_CH-1:0] w_wrr_ch;
  logic [ERR_W-1:0]  w_viol;
  logic              w_any;
  logic [2:0]        w_first_code;
  logic [2:0]        w_first_ch;

  logic [ERR_W-1:0]  r_err_sticky;
  logic              r_err_pulse;
  logic [2:0]        r_first_code;
  logic [2:0]        r_first_ch;
  logic [15:0]       r_err_cnt;

  assign w_mode  = arb_mode_e'(arb_mode);
  assign w_grant = awvalid & awready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WEIGHT_W-1:0] w_weight;
      logic [31:0]         w_wlim;
      logic                w_others_waiting;

      // A zero weight still allows one grant per turn.
      assign w_weight         = weight[gi*WEIGHT_W +: WEIGHT_W];
      assign w_wlim           = (w_weight == '0) ? 32'd1 : 32'(w_weight);
      assign w_others_waiting = |(w_valid_q & ~(NUM_CH'(1) << gi));

      // Channel 0 has top priority, so it can never be granted out of order.
      if (gi == 0) begin : g_top
        assign w_prio_ch[gi] = 1'b0;
      end else begin : g_low
        assign w_prio_ch[gi] = w_grant[gi] & (|awvalid[gi-1:0]);
      end

      // Run count is the number of grants already taken before this one.
      assign w_rr_ch[gi]  = w_grant[gi] & (32'(w_run_cnt[gi]) >= 32'(RR_BURST))
                            & w_others_waiting;
      assign w_wrr_ch[gi] = w_grant[gi] & (32'(w_run_cnt[gi]) >= w_wlim)
                            & w_others_waiting;

      axi_arb_mon_ch #(
        .NUM_CH   (NUM_CH),
        .CH_IDX   (gi),
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .aw        (w_aw_if),
        .i_arb_en  (arb_en),
        .o_run_cnt (w_run_cnt[gi]),
        .o_valid_q (w_valid_q[gi]),
        .o_starve  (w_starve[gi])
      );
    end
  endgenerate

  // Violations seen this cycle; policy checks depend on the current mode.
  always_comb begin
    w_viol              = '0;
    w_viol[VIOL_MULTI]  = |(w_grant & (w_grant - 1'b1));
    w_viol[VIOL_NOARB]  = ~arb_en & (|w_grant[NUM_CH-1:1]);
    if (arb_en) begin
      case (w_mode)
        MODE_FIXED: w_viol[VIOL_PRIO] = |w_prio_ch;
        MODE_RR:    w_viol[VIOL_RR]   = |w_rr_ch;
        MODE_WRR:   w_viol[VIOL_WRR]  = |w_wrr_ch;
        default:    w_viol[VIOL_PRIO] = 1'b0;
      endcase
    end
    w_viol[VIOL_STARVE] = |w_starve;
  end

  assign w_any = |w_viol;

  // Lowest-numbered violation and the lowest channel responsible for it.
  always_comb begin
    w_first_code = lowest_set(8'(w_viol));
    case (viol_code_e'(w_first_code))
      VIOL_PRIO:   w_first_ch = lowest_set(8'(w_prio_ch));
      VIOL_RR:     w_first_ch = lowest_set(8'(w_rr_ch));
      VIOL_WRR:    w_first_ch = lowest_set(8'(w_wrr_ch));
      VIOL_STARVE: w_first_ch = lowest_set(8'(w_starve));
      default:     w_first_ch = lowest_set(8'(w_grant));
    endcase
  end

  // Error bookkeeping; a violation coinciding with a clear restarts the record.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_sticky <= '0;
      r_err_pulse  <= 1'b0;
      r_first_code <= '0;
      r_first_ch   <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_err_pulse <= w_any;
      if (clr_err) begin
        r_err_sticky <= w_viol;
        r_err_cnt    <= {15'd0, w_any};
        r_first_code <= w_any ? w_first_code : 3'd0;
        r_first_ch   <= w_any ? w_first_ch : 3'd0;
      end else begin
        r_err_sticky <= r_err_sticky | w_viol;
        if (w_any && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
        if (w_any && (r_err_sticky == '0)) begin
          r_first_code <= w_first_code;
          r_first_ch   <= w_first_ch;
        end
      end
    end
  end

  assign err_sticky = r_err_sticky;
  assign err_pulse  = r_err_pulse;
  assign first_code = r_first_code;
  assign first_ch   = r_first_ch;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_axi_arb_monitor.sv
// Scenario bench for axi_arb_monitor (3 channels, starvation limit 4).
// Each step's required outputs are queued when the stimulus is driven and
// popped for comparison one clock later.
module tb_axi_arb_monitor;

  typedef struct packed {
    logic [5:0]  sticky;
    logic        pulse;
    logic [2:0]  code;
    logic [2:0]  ch;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic [2:0] v;
    logic [2:0] r;
    obs_t       exp;
  } step_t;

  logic        clk;
  logic        rst;
  logic        arb_en;
  logic [1:0]  arb_mode;
  logic [47:0] weight;
  logic        clr_err;
  logic [5:0]  err_sticky;
  logic        err_pulse;
  logic [2:0]  first_code;
  logic [2:0]  first_ch;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  obs_t exp_q[$];

  axi_arb_monitor_if #(.NUM_CH(3)) bus ();

  axi_arb_monitor #(
    .NUM_CH   (3),
    .CNT_W    (16),
    .WEIGHT_W (16),
    .MAX_WAIT (4),
    .RR_BURST (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .awvalid    (bus.awvalid),
    .awready    (bus.awready),
    .arb_en     (arb_en),
    .arb_mode   (arb_mode),
    .weight     (weight),
    .clr_err    (clr_err),
    .err_sticky (err_sticky),
    .err_pulse  (err_pulse),
    .first_code (first_code),
    .first_ch   (first_ch),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t mk(input logic r_st, input logic clr, input logic en,
                               input logic [1:0] mode, input logic [2:0] v,
                               input logic [2:0] rd, input logic [5:0] sticky,
                               input logic pulse, input logic [2:0] code,
                               input logic [2:0] ch, input logic [15:0] cnt);
    step_t s;
    s.rst = r_st; s.clr = clr; s.en = en; s.mode = mode; s.v = v; s.r = rd;
    s.exp = '{sticky: sticky, pulse: pulse, code: code, ch: ch, cnt: cnt};
    return s;
  endfunction

  task automatic apply(input step_t s);
    rst = s.rst; clr_err = s.clr; arb_en = s.en; arb_mode = s.mode;
    bus.awvalid = s.v; bus.awready = s.r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = '{sticky: err_sticky, pulse: err_pulse, code: first_code, ch: first_ch, cnt: err_cnt};
    return o;
  endfunction

  task automatic test_reset();
    step_t s[$];
    obs_t got, want;
    s.push_back(mk(1, 0, 0, 0, 3'b111, 3'b111, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    foreach (s[k]) begin
      apply(s[k]); exp_q.push_back(s[k].exp); tick();
      got = observe(); want = exp_q.pop_front(); n_checks++;
      $display("reset[%0d] v=%b r=%b -> %p", k, s[k].v, s[k].r, got);
      if (got !== want) $display("FAIL reset[%0d]: got %p want %p", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_prio();
    step_t s[$];
    obs_t got, want;
    s.push_back(mk(0, 0, 1, 0, 3'b011, 3'b010, 6'b000100, 1, 2, 1, 1));
    s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b000, 6'b000100, 0, 2, 1, 1));
    s.push_back(mk(0, 0, 1, 0, 3'b111, 3'b100, 6'b000100, 1, 2, 1, 2));
    s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b000, 6'b000100, 0, 2, 1, 2));
    s.push_back(mk(0, 0, 1, 0, 3'b101, 3'b001, 6'b000100, 0, 2, 1, 2));
    foreach (s[k]) begin
      apply(s[k]); exp_q.push_back(s[k].exp); tick();
      got = observe(); want = exp_q.pop_front(); n_checks++;
      $display("prio[%0d] v=%b r=%b -> %p", k, s[k].v, s[k].r, got);
      if (got !== want) $display("FAIL prio[%0d]: got %p want %p", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_clr_collision();
    step_t s[$];
    obs_t got, want;
    s.push_back(mk(0, 1, 1, 3, 3'b011, 3'b011, 6'b000001, 1, 0, 0, 1));
    s.push_back(mk(0, 0, 1, 3, 3'b000, 3'b000, 6'b000001, 0, 0, 0, 1));
    s.push_back(mk(0, 1, 1, 3, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    foreach (s[k]) begin
      apply(s[k]); exp_q.push_back(s[k].exp); tick();
      got = observe(); want = exp_q.pop_front(); n_checks++;
      $display("clr[%0d] v=%b r=%b clr=%b -> %p", k, s[k].v, s[k].r, s[k].clr, got);
      if (got !== want) $display("FAIL clr[%0d]: got %p want %p", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_rr();
    step_t s[$];
    obs_t got, want;
    s.push_back(mk(1, 0, 1, 1, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 3'b011, 3'b001, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 3'b011, 3'b001, 6'b001000, 1, 3, 0, 1));
    s.push_back(mk(1, 0, 1, 1, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 3'b111, 3'b001, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 3'b110, 3'b010, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 3'b100, 3'b100, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 3'b001, 3'b001, 6'b000000, 0, 0, 0, 0));
    foreach (s[k]) begin
      apply(s[k]); exp_q.push_back(s[k].exp); tick();
      got = observe(); want = exp_q.pop_front(); n_checks++;
      $display("rr[%0d] v=%b r=%b -> %p", k, s[k].v, s[k].r, got);
      if (got !== want) $display("FAIL rr[%0d]: got %p want %p", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_wrr();
    step_t s[$];
    obs_t got, want;
    s.push_back(mk(1, 0, 1, 2, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 2, 3'b100, 3'b000, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 2, 3'b011, 3'b001, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 2, 3'b101, 3'b001, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 2, 3'b011, 3'b001, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 2, 3'b101, 3'b001, 6'b010000, 1, 4, 0, 1));
    // channel 1 has weight 0, which must behave as weight 1
    s.push_back(mk(1, 0, 1, 2, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 2, 3'b110, 3'b010, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 2, 3'b011, 3'b010, 6'b010000, 1, 4, 1, 1));
    foreach (s[k]) begin
      apply(s[k]); exp_q.push_back(s[k].exp); tick();
      got = observe(); want = exp_q.pop_front(); n_checks++;
      $display("wrr[%0d] v=%b r=%b -> %p", k, s[k].v, s[k].r, got);
      if (got !== want) $display("FAIL wrr[%0d]: got %p want %p", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_starve();
    step_t s[$];
    obs_t got, want;
    s.push_back(mk(1, 0, 1, 3, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    for (int c = 1; c <= 10; c++) begin
      if (c < 4)       s.push_back(mk(0, 0, 1, 3, 3'b100, 3'b000, 6'b000000, 0, 0, 0, 0));
      else if (c == 4) s.push_back(mk(0, 0, 1, 3, 3'b100, 3'b000, 6'b100000, 1, 5, 2, 1));
      else             s.push_back(mk(0, 0, 1, 3, 3'b100, 3'b000, 6'b100000, 0, 5, 2, 1));
    end
    foreach (s[k]) begin
      apply(s[k]); exp_q.push_back(s[k].exp); tick();
      got = observe(); want = exp_q.pop_front(); n_checks++;
      $display("starve[%0d] v=%b r=%b -> %p", k, s[k].v, s[k].r, got);
      if (got !== want) $display("FAIL starve[%0d]: got %p want %p", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    step_t s[$];
    obs_t got, want;
    s.push_back(mk(1, 0, 1, 3, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++)
      s.push_back(mk(0, 0, 1, 3, 3'b100, 3'b000, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 1, 3, 3'b100, 3'b000, 6'b000000, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++)
      s.push_back(mk(0, 0, 1, 3, 3'b100, 3'b000, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 3, 3'b100, 3'b000, 6'b100000, 1, 5, 2, 1));
    foreach (s[k]) begin
      apply(s[k]); exp_q.push_back(s[k].exp); tick();
      got = observe(); want = exp_q.pop_front(); n_checks++;
      $display("midstall[%0d] rst=%b v=%b r=%b -> %p", k, s[k].rst, s[k].v, s[k].r, got);
      if (got !== want) $display("FAIL midstall[%0d]: got %p want %p", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_noarb_reset();
    step_t s[$];
    obs_t got, want;
    s.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 3'b001, 3'b001, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 3'b100, 3'b100, 6'b000010, 1, 1, 2, 1));
    s.push_back(mk(1, 0, 0, 0, 3'b100, 3'b100, 6'b000000, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 3'b000, 3'b000, 6'b000000, 0, 0, 0, 0));
    foreach (s[k]) begin
      apply(s[k]); exp_q.push_back(s[k].exp); tick();
      got = observe(); want = exp_q.pop_front(); n_checks++;
      $display("noarb[%0d] en=%b rst=%b v=%b r=%b -> %p", k, s[k].en, s[k].rst, s[k].v, s[k].r, got);
      if (got !== want) $display("FAIL noarb[%0d]: got %p want %p", k, got, want);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; clr_err = 1'b0; arb_en = 1'b0; arb_mode = 2'd0;
    bus.awvalid = '0; bus.awready = '0;
    weight = {16'd1, 16'd0, 16'd3};
    #1;
    test_reset();
    test_prio();
    test_clr_collision();
    test_rr();
    test_wrr();
    test_starve();
    test_reset_mid_stall();
    test_noarb_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_arb_monitor.md
AXI_ARB_MONITOR -- requirements
Module: axi_arb_monitor

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_CH, 3, monitored write-address channels, legal range 2..8.
- CNT_W, 16, width of the run counter and the wait counter.
- WEIGHT_W, 16, width of each weight field.
- MAX_WAIT, 256, starvation limit in cycles; 0 disables the starvation check.
- RR_BURST, 1, consecutive grants allowed in round-robin mode.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- awvalid, in, NUM_CH, per-channel AWVALID.
- awready, in, NUM_CH, per-channel AWREADY.
- arb_en, in, 1, arbiter enable.
- arb_mode, in, 2, arbitration mode: 0 fixed, 1 round-robin, 2 weighted, 3 reserved.
- weight, in, NUM_CH*WEIGHT_W, per-channel weights; channel i occupies slice [i*WEIGHT_W +: WEIGHT_W].
- clr_err, in, 1, clears the error state.
- err_sticky, out, 6, sticky flags: [0] multi-grant, [1] noarb, [2] prio, [3] rr, [4] wrr, [5] starve.
- err_pulse, out, 1, one-cycle pulse on any violation.
- first_code, out, 3, index of the first flagged violation.
- first_ch, out, 3, channel of the first flagged violation.
- err_cnt, out, 16, saturating count of violation cycles.

Function
REQ-003 grant[i] = awvalid[i] & awready[i]; all checks are evaluated on each rising edge of clk when rst=0.

REQ-004 Multi-grant check: two or more grant bits set in one cycle -> violation 0 (checked in all modes).

REQ-005 Noarb check: arb_en=0 and grant on any channel other than 0 -> violation 1.

REQ-006 Fixed-priority check: arb_en=1, arb_mode=0, grant[j], and awvalid[i] with i<j -> violation 2 (lower index has priority).

REQ-007 Run counter run_cnt[i]:
- Increments on grant[i] when arb_en=1, saturating at 2^CNT_W-1.
- Clears to 0 on a grant to any other channel.
- Holds otherwise.

REQ-008 Valid delay: valid_q[i] registers awvalid[i] every cycle.

REQ-009 Round-robin check: arb_en=1, arb_mode=1, grant[j], run_cnt[j]>=RR_BURST, and valid_q[i] for some i!=j -> violation 3.

REQ-010 Weighted check: arb_en=1, arb_mode=2, grant[j], run_cnt[j]>=max(weight[j],1), and valid_q[i] for some i!=j -> violation 4. A weight of 0 is treated as 1.

REQ-011 arb_mode=3 disables the mode checks only; REQ-004, REQ-005 and REQ-013 remain active.

REQ-012 Wait counter wait_cnt[i]:
- Increments while awvalid[i] & ~awready[i], saturating at MAX_WAIT.
- Clears on awready[i] or on ~awvalid[i].

REQ-013 Starvation check: when arb_en=1, MAX_WAIT!=0, and wait_cnt[i] transitions to MAX_WAIT -> violation 5. It fires once per stall.

REQ-014 Error reporting on any violation in a cycle:
- Next cycle: the matching err_sticky bits are set and err_pulse=1 for exactly one cycle.
- err_cnt increments by 1 per violating cycle, not per violation, saturating at 0xFFFF.

REQ-015 first_code/first_ch capture the lowest-numbered violation and its lowest channel, only while err_sticky==0. For channel-less violations (0, 1) first_ch reports the lowest granted channel.

REQ-016 clr_err clears err_sticky, first_code, first_ch and err_cnt next cycle. If a violation occurs in the same cycle as clr_err, the violation wins: the state is loaded fresh with the new violation's values and err_cnt=1.

REQ-017 Mode or weight changes take effect in the same cycle. Counters are not cleared on a mode change.

Reset
REQ-018 On rst=1 at a clock edge, all of these are 0 on the next cycle: run_cnt, wait_cnt, valid_q, err_sticky, err_pulse, first_code, first_ch, err_cnt.

REQ-019 Reset mid-stall or mid-burst discards all history; no violation is flagged in the rst cycle.

Structure
REQ-020 Package axi_arb_mon_pkg holds:
- The mode enum: MODE_FIXED, MODE_RR, MODE_WRR, MODE_RSVD.
- The violation-code enum, values 0..5.
- The ERR_W=6 constant.

REQ-021 Sub-module axi_arb_mon_ch is instantiated NUM_CH times. It holds run_cnt, wait_cnt and valid_q, and outputs the per-channel starve flag and run_cnt.

Verification
REQ-022 Setup: NUM_CH=3. Stimulus: arb_en=1, mode 0, awvalid=3'b011, grant on ch1 only. Required response: err_sticky[2]=1, first_code=2, first_ch=1, err_pulse for one cycle.

REQ-023 Stimulus: mode 1, RR_BURST=1, ch0 granted two consecutive cycles while valid_q[1]=1. Required response: err_sticky[3] set on the second grant; a 0->1->2 rotation gives no error.

REQ-024 Stimulus: mode 2, weight0=3, ch0 granted 4 times back-to-back with ch2 valid. Required response: only the 4th grant flags err_sticky[4]; the first three do not.

REQ-025 Stimulus: MAX_WAIT=4, awvalid[2] held with awready[2]=0 for 10 cycles. Required response: err_sticky[5]=1 after the 4th stall cycle, and err_cnt=1.

REQ-026 Stimulus: grants on ch0 and ch1 in the same cycle that clr_err is asserted. Required response: err_sticky=6'b000001 and err_cnt=1.

REQ-027 Stimulus: arb_en=0, grant on ch2, rst asserted the following cycle. Required response: err_sticky[1] set, then all outputs 0 after reset.
